aes_sbox_share_ctrl: RTL
========================

# aes_sbox_share_ctrl

Time-multiplexes one shared 32-bit word S-box (four byte S-boxes) between two requesters: the round datapath, which needs SubBytes on a 128-bit state, and the key expansion, which needs SubWord on one 32-bit word. The 128-bit state is processed one word per cycle over four cycles, so the design needs one word S-box instead of five. The block sits between the round controller and key scheduler on one side and the externally instantiated word S-box on the other.

## Interface
Parameters:
- ROUND_ROBIN, default 0: 0 = key requester has fixed priority; 1 = alternate grants on contention.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low; one clock domain only.
- st_valid  in  1  state request valid.
- st_ready  out  1  state request accepted when st_valid && st_ready.
- st_data  in  128  state to substitute; word k = bits [32k+31:32k].
- st_out_valid  out  1  one-cycle pulse; st_out is valid.
- st_out  out  128  SubBytes(st_data).
- key_valid  in  1  key request valid.
- key_ready  out  1  key request accepted when key_valid && key_ready.
- key_word  in  32  word to substitute.
- key_out_valid  out  1  one-cycle pulse; key_out is valid.
- key_out  out  32  SubWord(key_word).
- sbox_in  out  32  drives the shared word S-box input.
- sbox_out  in  32  combinational result from the shared word S-box.

## Operation
- FSM states: IDLE, ST_SUB (4 cycles), KEY_SUB (1 cycle).
- Requests are accepted only in IDLE. A ready output depends on the FSM state, on the other requester's valid and on the priority bit. It never depends on its own valid.
- Arbitration in IDLE:
  - Only one valid: that requester is granted.
  - Both valid, ROUND_ROBIN=0: key is granted and st_ready=0.
  - Both valid, ROUND_ROBIN=1: the requester not granted last is granted. The last_grant bit updates on every accepted handshake.
- Handshake: st_data or key_word is captured into an internal input register, and the FSM moves to ST_SUB or KEY_SUB.
- ST_SUB:
  - A 2-bit word counter runs 0..3 and starts at 0.
  - sbox_in = captured word[cnt]; sbox_out is registered into result word[cnt].
  - After cnt=3 the FSM returns to IDLE.
- KEY_SUB: sbox_in = captured key word; sbox_out is registered into key_out; the FSM returns to IDLE.
- sbox_in = 32'h0 in IDLE.
- st_out and key_out hold their last value until overwritten by the next completion. Partial state results are never exposed: st_out updates only as a whole when st_out_valid is asserted.
- Input ports are not sampled after the handshake, so requesters may change data freely.

## Timing
- Reset values:
  - FSM = IDLE, cnt = 0, last_grant = state (so the first RR contention goes to key).
  - st_out_valid = 0, key_out_valid = 0, st_out = 0, key_out = 0, sbox_in = 0.
  - st_ready and key_ready follow IDLE arbitration immediately after reset.
- State request accepted at edge T:
  - Words 0..3 are presented on sbox_in in cycles T+1..T+4.
  - st_out_valid is high for exactly cycle T+5.
  - The FSM is in IDLE in cycle T+5, so a new request can be accepted at the edge ending T+5.
  - Throughput is one state per 5 cycles.
- Key request accepted at edge T: the word is on sbox_in in T+1; key_out_valid is high for cycle T+2; the block is back in IDLE in T+2.
- A request arriving while the block is busy sees ready=0 and must hold valid. It is not dropped.
- st_out_valid and key_out_valid are never high in the same cycle.
- Reset asserted mid-operation:
  - Outputs clear asynchronously and the operation is abandoned.
  - No out_valid pulse follows deassertion.
  - The requester must reissue.
- The S-box path is combinational from sbox_in to sbox_out to the result register. One S-box delay must fit in a cycle.

## Test plan
- Reset, then st_data=128'h0 accepted at T → sbox_in = 0 for T+1..T+4; st_out_valid only at T+5; st_out = 128'h63636363_63636363_63636363_63636363.
- key_word=32'h01010101 accepted at T → key_out_valid at T+2; key_out = 32'h7c7c7c7c; key_ready=1 again in T+2.
- st_data = 128'h53535353_00000000_01010101_53000001 → st_out = 128'hEDEDEDED_63636363_7C7C7C7C_ED63637C. Words must appear on sbox_in in order 32'h53000001, 32'h01010101, 32'h0, 32'h53535353.
- Contention: st_valid and key_valid both high in IDLE.
  - ROUND_ROBIN=0: key is served first and the state handshake occurs at T+2.
  - ROUND_ROBIN=1 with both held valid: grants alternate key, state, key, state.
- Key request raised during ST_SUB → key_ready=0 until the state completes; key is accepted in the st_out_valid cycle; key_out_valid follows 2 cycles later.
- rst_n pulled low at cycle T+2 of a state operation → outputs are 0 immediately; no st_out_valid after release; the next request completes normally.

Source files
------------

// File: rtl/aes_sbox_share_ctrl.sv
// Shares one external 32-bit word S-box between the round datapath (SubBytes on a
// 128-bit state, one word per cycle) and the key schedule (SubWord on one word).
module aes_sbox_share_ctrl #(
  parameter int unsigned ROUND_ROBIN = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_data,
  output logic         st_out_valid,
  output logic [127:0] st_out,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [31:0]  key_word,
  output logic         key_out_valid,
  output logic [31:0]  key_out,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out
);

  localparam bit   RR        = (ROUND_ROBIN != 0);
  localparam logic GRANT_KEY = 1'b0;
  localparam logic GRANT_ST  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_SUB  = 2'd1,
    KEY_SUB = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         last_grant_q, last_grant_d;
  logic [127:0] st_buf_q, st_buf_d;
  logic [31:0]  key_buf_q, key_buf_d;
  logic [95:0]  st_acc_q, st_acc_d;
  logic [127:0] st_out_q, st_out_d;
  logic [31:0]  key_out_q, key_out_d;
  logic         st_out_valid_q, st_out_valid_d;
  logic         key_out_valid_q, key_out_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= 2'd0;
      last_grant_q    <= GRANT_ST;
      st_buf_q        <= '0;
      key_buf_q       <= '0;
      st_acc_q        <= '0;
      st_out_q        <= '0;
      key_out_q       <= '0;
      st_out_valid_q  <= 1'b0;
      key_out_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      last_grant_q    <= last_grant_d;
      st_buf_q        <= st_buf_d;
      key_buf_q       <= key_buf_d;
      st_acc_q        <= st_acc_d;
      st_out_q        <= st_out_d;
      key_out_q       <= key_out_d;
      st_out_valid_q  <= st_out_valid_d;
      key_out_valid_q <= key_out_valid_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    last_grant_d    = last_grant_q;
    st_buf_d        = st_buf_q;
    key_buf_d       = key_buf_q;
    st_acc_d        = st_acc_q;
    st_out_d        = st_out_q;
    key_out_d       = key_out_q;
    st_out_valid_d  = 1'b0;
    key_out_valid_d = 1'b0;
    st_ready        = 1'b0;
    key_ready       = 1'b0;
    sbox_in         = 32'h0;

    case (state_q)
      IDLE: begin
        // Readies look only at the other side's valid, so at most one handshake fires.
        st_ready  = !key_valid || (RR && (last_grant_q == GRANT_KEY));
        key_ready = !st_valid || !RR || (last_grant_q == GRANT_ST);
        if (key_valid && key_ready) begin
          key_buf_d    = key_word;
          last_grant_d = GRANT_KEY;
          state_d      = KEY_SUB;
        end else if (st_valid && st_ready) begin
          st_buf_d     = st_data;
          cnt_d        = 2'd0;
          last_grant_d = GRANT_ST;
          state_d      = ST_SUB;
        end
      end

      ST_SUB: begin
        cnt_d = cnt_q + 2'd1;
        case (cnt_q)
          2'd0: begin
            sbox_in         = st_buf_q[31:0];
            st_acc_d[31:0]  = sbox_out;
          end
          2'd1: begin
            sbox_in         = st_buf_q[63:32];
            st_acc_d[63:32] = sbox_out;
          end
          2'd2: begin
            sbox_in         = st_buf_q[95:64];
            st_acc_d[95:64] = sbox_out;
          end
          default: begin
            // Last word goes straight to the output so partial results never appear.
            sbox_in        = st_buf_q[127:96];
            st_out_d       = {sbox_out, st_acc_q};
            st_out_valid_d = 1'b1;
            state_d        = IDLE;
          end
        endcase
      end

      KEY_SUB: begin
        sbox_in         = key_buf_q;
        key_out_d       = sbox_out;
        key_out_valid_d = 1'b1;
        state_d         = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  assign st_out        = st_out_q;
  assign key_out       = key_out_q;
  assign st_out_valid  = st_out_valid_q;
  assign key_out_valid = key_out_valid_q;

  // Invariants: completions never coincide, and contention never grants both sides.
  assert property (@(posedge clk) disable iff (!rst_n) !(st_out_valid && key_out_valid));
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(st_valid && key_valid && st_ready && key_ready));

endmodule
